// File: rtl/mesh_pkg.sv
// Shared constants and FSM encoding for the mesh result reader.
package mesh_pkg;

  localparam int MESH_ROWS  = 18;
  localparam int MESH_COLS  = 26;
  localparam int MESH_NODES = MESH_ROWS * MESH_COLS;
  localparam int ROW_IDX_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mesh_result_reader_if.sv
// Row stream handshake between the reader (master) and its consumer (slave).
interface mesh_result_reader_if #(
  parameter int COLS  = mesh_pkg::MESH_COLS,
  parameter int IDX_W = mesh_pkg::ROW_IDX_W
);
  logic [COLS-1:0]  row_data;
  logic [IDX_W-1:0] row_idx;
  logic             row_valid;
  logic             row_ready;
  logic             row_last;

  modport master (output row_data, output row_idx, output row_valid, output row_last,
                  input row_ready);
  modport slave  (input row_data, input row_idx, input row_valid, input row_last,
                  output row_ready);
endinterface

// File: rtl/mesh_row_select.sv
// Picks one row word out of the flattened mesh vector; node j sits at bit NODES-1-j.
module mesh_row_select
  import mesh_pkg::*;
#(
  parameter int ROWS  = MESH_ROWS,
  parameter int COLS  = MESH_COLS,
  parameter int IDX_W = ROW_IDX_W
) (
  input  logic [ROWS*COLS-1:0] shadow,
  input  logic [IDX_W-1:0]     row_idx,
  output logic [COLS-1:0]      row_word
);

  localparam int NODES = ROWS * COLS;

  logic [ROWS-1:0][COLS-1:0] rows_w;

  genvar gi, gt;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gt = 0; gt < COLS; gt++) begin : g_col
        assign rows_w[gi][gt] = shadow[NODES-1-(COLS*gi+gt)];
      end
    end
  endgenerate

  always_comb begin
    row_word = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_idx == IDX_W'(r)) row_word = rows_w[r];
    end
  end

endmodule

// File: rtl/mesh_result_reader.sv
// Captures the mesh result LATENCY cycles after the scan strobe and streams it
// out one row per handshake.
module mesh_result_reader
  import mesh_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ROWS    = MESH_ROWS,
  parameter int COLS    = MESH_COLS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 high,
  input  logic [ROWS*COLS-1:0] mesh_out,
  mesh_result_reader_if.master rd,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ROWS*COLS-1:0]  shadow_q, shadow_d;
  logic                  overrun_q, overrun_d;
  logic [COLS-1:0]       sel_word;
  logic                  row_valid;
  logic                  at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      overrun_q <= overrun_d;
    end
  end

  assign row_valid = (state_q == ST_STREAM);
  assign at_last   = (idx_q == IDX_W'(ROWS-1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    // Any strobe seen outside IDLE is dropped and flagged, never restarts.
    overrun_d = high && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (high) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LATENCY-1)) begin
          state_d  = ST_STREAM;
          cnt_d    = '0;
          shadow_d = mesh_out;
          idx_d    = '0;
        end
      end
      ST_STREAM: begin
        if (rd.row_ready) begin
          if (at_last) state_d = ST_DONE;
          else         idx_d   = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  mesh_row_select #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_row_select (
    .shadow   (shadow_q),
    .row_idx  (idx_q),
    .row_word (sel_word)
  );

  assign rd.row_valid = row_valid;
  assign rd.row_idx   = idx_q;
  assign rd.row_data  = row_valid ? sel_word : '0;
  assign rd.row_last  = row_valid && at_last;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_mesh_result_reader.sv
// Directed bench for mesh_result_reader with a row scoreboard filled at frame start.
module tb_mesh_result_reader;
  import mesh_pkg::*;

  typedef struct packed {
    logic [4:0]  idx;
    logic [25:0] data;
    logic        last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         high;
  logic [467:0] mesh_out;
  logic         busy, done, overrun;

  int   checks = 0;
  int   failures = 0;
  int   xfers = 0;
  int   cyc = 0;
  int   t0 = 0;
  exp_t sb[$];

  mesh_result_reader_if #(.COLS(26), .IDX_W(5)) rd_if ();

  mesh_result_reader #(.LATENCY(4), .ROWS(18), .COLS(26)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .high     (high),
    .mesh_out (mesh_out),
    .rd       (rd_if),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [25:0] row_of(input logic [467:0] m, input int r);
    logic [25:0] w;
    for (int t = 0; t < 26; t++) w[t] = m[467 - (26*r + t)];
    return w;
  endfunction

  // Pulses high for one cycle, fills the scoreboard and returns just after capture.
  task automatic start_frame(input logic [467:0] m);
    exp_t e;
    mesh_out = m;
    xfers = 0;
    for (int r = 0; r < 18; r++) begin
      e.idx  = 5'(r);
      e.data = row_of(m, r);
      e.last = (r == 17);
      sb.push_back(e);
    end
    high = 1'b1;
    step();
    high = 1'b0;
    check("busy_after_high", {31'b0, busy}, 32'd1);
    repeat (3) step();
    check("valid_before_latency", {31'b0, rd_if.row_valid}, 32'd0);
    step();
    check("valid_at_latency", {31'b0, rd_if.row_valid}, 32'd1);
    check("first_row_idx", {27'b0, rd_if.row_idx}, 32'd0);
    t0 = cyc;
  endtask

  task automatic wait_idx(input logic [4:0] k);
    int n = 0;
    while (rd_if.row_idx !== k && n < 50) begin
      step();
      n++;
    end
    check("reach_row_idx", {27'b0, rd_if.row_idx}, {27'b0, k});
  endtask

  task automatic finish_frame(input int exp_cycles);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("cycles_to_done", cyc - t0, exp_cycles);
    check("xfer_count", xfers, 32'd18);
    check("valid_low_in_done", {30'b0, rd_if.row_valid, rd_if.row_last}, 32'd0);
    step();
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("idle_after_done", {31'b0, busy}, 32'd0);
    check("scoreboard_empty", sb.size(), 32'd0);
  endtask

  initial begin
    logic [467:0] m;
    logic [25:0]  held;

    rst_n = 1'b0;
    high = 1'b0;
    mesh_out = '0;
    rd_if.row_ready = 1'b1;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n === 1'b1 && rd_if.row_valid === 1'b1 && rd_if.row_ready === 1'b1) begin
          checks++;
          assert (sb.size() != 0)
          else begin
            failures++;
            $error("FAIL unexpected_row observed_idx=%0d expected=none", rd_if.row_idx);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            $display("xfer row_idx=%0d row_data=%07h row_last=%0b", rd_if.row_idx,
                     rd_if.row_data, rd_if.row_last);
            check("row_idx", {27'b0, rd_if.row_idx}, {27'b0, e.idx});
            check("row_data", {6'b0, rd_if.row_data}, {6'b0, e.data});
            check("row_last", {31'b0, rd_if.row_last}, {31'b0, e.last});
            xfers++;
          end
        end
      end
      begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
      end
    join_none

    repeat (2) step();
    check("reset_outputs", {rd_if.row_data, rd_if.row_idx, rd_if.row_valid, rd_if.row_last},
          32'd0);
    check("reset_flags", {29'b0, busy, done, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_no_high", {31'b0, busy}, 32'd0);

    // Alternating pattern, ready always high.
    for (int j = 0; j < 468; j++) m[467-j] = 1'(j % 2);
    start_frame(m);
    check("pattern_row0", {6'b0, rd_if.row_data}, 32'h2AAAAAA);
    finish_frame(18);

    // Random contents with a three-cycle stall at row 5.
    for (int i = 0; i < 468; i++) m[i] = 1'($urandom_range(0, 1));
    start_frame(m);
    wait_idx(5'd5);
    rd_if.row_ready = 1'b0;
    held = rd_if.row_data;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_valid", {31'b0, rd_if.row_valid}, 32'd1);
      check("stall_idx", {27'b0, rd_if.row_idx}, 32'd5);
      check("stall_data", {6'b0, rd_if.row_data}, {6'b0, held});
    end
    rd_if.row_ready = 1'b1;
    finish_frame(21);

    // Capture zeros, then drive ones the cycle after capture.
    start_frame('0);
    mesh_out = '1;
    check("post_capture_data", {6'b0, rd_if.row_data}, 32'd0);
    finish_frame(18);

    // Strobe during streaming must only raise overrun.
    for (int i = 0; i < 468; i++) m[i] = 1'($urandom_range(0, 1));
    start_frame(m);
    wait_idx(5'd9);
    high = 1'b1;
    step();
    high = 1'b0;
    check("overrun_pulse", {31'b0, overrun}, 32'd1);
    check("no_restart_idx", {27'b0, rd_if.row_idx}, 32'd10);
    step();
    check("overrun_cleared", {31'b0, overrun}, 32'd0);
    finish_frame(18);

    // Asynchronous reset at row 7 abandons the frame.
    for (int i = 0; i < 468; i++) m[i] = 1'($urandom_range(0, 1));
    start_frame(m);
    wait_idx(5'd7);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {rd_if.row_data, rd_if.row_idx, rd_if.row_valid, rd_if.row_last}, 32'd0);
    check("async_reset_flags", {29'b0, busy, done, overrun}, 32'd0);
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_reset_quiet", {30'b0, busy, done}, 32'd0);
    end
    for (int i = 0; i < 468; i++) m[i] = 1'($urandom_range(0, 1));
    start_frame(m);
    finish_frame(18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesh_result_reader.md
MESH_RESULT_READER -- requirements
Module: mesh_result_reader

Interface
REQ-001 Parameter LATENCY, default 4: cycles from the sampled high strobe until mesh result is valid.
REQ-002 Parameter ROWS, default 18: mesh rows streamed per frame.
REQ-003 Parameter COLS, default 26: nodes per row, equal to the row_data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 high  input  1  scan-complete strobe, the same signal that drives the mesh high input.
REQ-007 mesh_out  input  468  mesh result vector; node j result is mesh_out[467-j].
REQ-008 row_data  output  26  current row; bit t = node (26*row_idx + t) result.
REQ-009 row_idx  output  5  index of the row presented, 0..17.
REQ-010 row_valid  output  1  row_data/row_idx/row_last valid.
REQ-011 row_ready  input  1  downstream accepts the row.
REQ-012 row_last  output  1  high with row_valid when row_idx = ROWS-1.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the last row transfers.
REQ-015 overrun  output  1  one-cycle pulse when high is sampled while busy.

Function
REQ-016 FSM states: IDLE, WAIT, STREAM, DONE.
- IDLE -> WAIT when high = 1 at the rising edge; latency counter loads 0.
- WAIT: counter increments each cycle.
- WAIT -> STREAM on the edge where the counter reaches LATENCY-1.
- STREAM -> DONE on the handshake with row_idx = ROWS-1.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 On the WAIT -> STREAM edge, all 468 bits of mesh_out are captured into a shadow register, and row_idx is set to 0.
- row_valid is first high LATENCY cycles after the edge that sampled high.
REQ-018 Streamed data comes only from the shadow register; mesh_out changes after capture have no effect.
REQ-019 Transfer occurs on an edge with row_valid = 1 and row_ready = 1.
- row_idx increments by 1 on each transfer.
- row_valid stays high between rows, with no bubble.
REQ-020 While row_valid = 1 and row_ready = 0, row_data, row_idx and row_last are held stable.
REQ-021 row_ready is ignored when row_valid = 0.
- row_valid does not depend combinationally on row_ready.
REQ-022 row_valid and row_last are low in DONE and IDLE.
- done = 1 only in DONE.
REQ-023 high is ignored in WAIT, STREAM and DONE, with no restart.
- overrun pulses for each such sampled high.
REQ-024 When high is sampled in IDLE, the strobe is accepted regardless of its level in later cycles.
- A multi-cycle high produces exactly one frame plus overrun pulses for each later sampled cycle.
REQ-025 row_idx never exceeds ROWS-1 and does not wrap within a frame.
REQ-026 Throughput: with row_ready held high, a frame takes LATENCY + ROWS + 1 cycles from the sampled high to the return to IDLE.

Reset
REQ-027 rst_n = 0 immediately forces state IDLE.
- All outputs go to 0: row_data, row_idx, row_valid, row_last, busy, done, overrun.
- The shadow register and latency counter clear to 0.
REQ-028 Reset asserted mid-WAIT or mid-STREAM abandons the frame.
- No done pulse is produced.
- After release, the block waits for a fresh high.

Structure
REQ-029 Package mesh_pkg holds:
- constants MESH_ROWS=18, MESH_COLS=26, MESH_NODES=468, ROW_IDX_W=5;
- the FSM state encoding.
REQ-030 Row extraction is a combinational sub-module, mesh_row_select (shadow vector + row index -> 26-bit row word); the FSM, counters and shadow register stay in mesh_result_reader.

Verification
REQ-031 Node j result = j%2, high pulsed 1 cycle, row_ready = 1:
- row_valid rises 4 cycles after the sampled high;
- 18 consecutive rows, each row_data = 26'h2AAAAAA (bit t = t%2);
- row_last only at row 17; done pulses 1 cycle later.
REQ-032 Backpressure: row_ready low for 3 cycles at row 5:
- row_idx = 5 and row_data are held for those 3 cycles;
- the frame completes with 18 transfers, none duplicated or skipped.
REQ-033 mesh_out changed to all-ones in the cycle after capture, with captured value all-zeros -> every streamed row = 26'h0.
REQ-034 high re-pulsed during STREAM at row 9 -> overrun pulses once, no restart, row_idx continues 10..17.
REQ-035 rst_n asserted at row 7 -> all outputs 0 asynchronously, no done pulse; a new high afterwards yields a full frame starting at row 0.
